// File: rtl/icache_sa_if.sv
// Fetch-side request/response and refill-side bus of the set-associative instruction cache.
// The slave modport is the cache view; master is the fetch unit plus instruction memory.
interface icache_sa_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
);
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic              resp_hit;
   logic              flush;
   logic              mem_req_valid;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_ready;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_resp_data;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;

   modport slave (
      input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
      output req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr,
             hit_count, miss_count
   );

   modport master (
      output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
      input  req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr,
             hit_count, miss_count
   );
endinterface

// File: rtl/icache_sa.sv
// Set-associative read-only instruction cache: registered-read tag/data arrays per way,
// blocking miss FSM with burst line refill, deferred flush and saturating hit/miss counters.
module icache_sa #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int SETS       = 16,
   parameter int WAYS       = 2,
   parameter int LINE_WORDS = 4,
   parameter int CNT_W      = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   icache_sa_if.slave  bus
);
   localparam int OFF_W = $clog2(DATA_W / 8);
   localparam int WI_W  = $clog2(LINE_WORDS);
   localparam int SI_W  = $clog2(SETS);
   localparam int TAG_W = ADDR_W - OFF_W - WI_W - SI_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int LA_W  = OFF_W + WI_W;

   typedef enum logic [1:0] {LOOKUP, MISS_REQ, REFILL, RESP} state_t;

   state_t             state_q, state_d;
   logic               pending_q, pending_d;
   logic [ADDR_W-1:0]  addr_q;
   logic [WAY_W-1:0]   way_q;
   logic               evict_q;
   logic [WI_W-1:0]    beat_q;
   logic [DATA_W-1:0]  resp_word_q;
   logic               flush_pend_q, flush_pend_d;
   logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;
   logic [WAY_W-1:0]   victim_q [SETS];

   logic [TAG_W-1:0]   tag_f;
   logic [SI_W-1:0]    set_f, req_set;
   logic [WI_W-1:0]    word_f, req_word;
   logic [WAYS-1:0]    hit_vec, set_valid;
   logic [DATA_W-1:0]  rd_data [WAYS];
   logic [DATA_W-1:0]  hit_data;
   logic               lookup, hit, miss, accept, beat_we, line_done, do_flush;
   logic [WAY_W-1:0]   fill_way, next_victim;
   logic               fill_evict;
   logic               req_ready_c, resp_valid_c, resp_hit_c, mem_req_valid_c;
   logic [DATA_W-1:0]  resp_data_c;
   logic [ADDR_W-1:0]  mem_req_addr_c;
   logic               unused_lsb;

   assign tag_f    = addr_q[ADDR_W-1 -: TAG_W];
   assign set_f    = addr_q[LA_W +: SI_W];
   assign word_f   = addr_q[OFF_W +: WI_W];
   assign req_set  = bus.req_addr[LA_W +: SI_W];
   assign req_word = bus.req_addr[OFF_W +: WI_W];

   generate
      if (OFF_W > 0) begin : g_lsb
         assign unused_lsb = ^{addr_q[OFF_W-1:0], bus.req_addr[OFF_W-1:0]};
      end else begin : g_no_lsb
         assign unused_lsb = 1'b0;
      end
   endgenerate

   assign lookup    = (state_q == LOOKUP) && pending_q;
   assign hit       = lookup && (|hit_vec);
   assign miss      = lookup && !(|hit_vec);
   assign accept    = bus.req_valid && req_ready_c;
   assign beat_we   = (state_q == REFILL) && bus.mem_resp_valid;
   assign line_done = beat_we && (beat_q == WI_W'(LINE_WORDS - 1));
   // A flush raised outside LOOKUP is held and lands on the RESP -> LOOKUP edge.
   assign do_flush  = ((state_q == LOOKUP) && bus.flush) ||
                      ((state_q == RESP) && (flush_pend_q || bus.flush));

   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         logic [TAG_W-1:0]  tag_mem  [SETS];
         logic [DATA_W-1:0] data_mem [SETS*LINE_WORDS];
         logic [TAG_W-1:0]  rd_tag_q;
         logic [DATA_W-1:0] rd_data_q;
         logic [SETS-1:0]   valid_q;
         logic              sel;

         assign sel = (way_q == WAY_W'(gi));

         always_ff @(posedge clk) begin
            if (beat_we && sel)
               data_mem[{set_f, beat_q}] <= bus.mem_resp_data;
            if (line_done && sel)
               tag_mem[set_f] <= tag_f;
            if (accept) begin
               rd_data_q <= data_mem[{req_set, req_word}];
               rd_tag_q  <= tag_mem[req_set];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               valid_q <= '0;
            else if (do_flush)
               valid_q <= '0;
            else if (line_done && sel)
               valid_q[set_f] <= 1'b1;
         end

         assign set_valid[gi] = valid_q[set_f];
         assign hit_vec[gi]   = valid_q[set_f] && (rd_tag_q == tag_f);
         assign rd_data[gi]   = rd_data_q;
      end
   endgenerate

   always_comb begin
      hit_data = '0;
      for (int w = 0; w < WAYS; w++)
         if (hit_vec[w]) hit_data = rd_data[w];
   end

   // Lowest invalid way wins; only a full set consults the victim pointer.
   always_comb begin
      fill_way   = victim_q[set_f];
      fill_evict = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!set_valid[w]) begin
            fill_way   = WAY_W'(w);
            fill_evict = 1'b0;
         end
      end
   end

   assign next_victim = (way_q == WAY_W'(WAYS - 1)) ? '0 : way_q + WAY_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOOKUP;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOOKUP:   if (miss) state_d = MISS_REQ;
         MISS_REQ: if (bus.mem_req_ready) state_d = REFILL;
         REFILL:   if (line_done) state_d = RESP;
         RESP:     state_d = LOOKUP;
         default:  state_d = LOOKUP;
      endcase
   end

   always_comb begin
      req_ready_c     = (state_q == LOOKUP) && !miss && !bus.flush;
      resp_valid_c    = hit || (state_q == RESP);
      resp_hit_c      = hit;
      resp_data_c     = '0;
      mem_req_valid_c = (state_q == MISS_REQ);
      mem_req_addr_c  = '0;
      if (hit)
         resp_data_c = hit_data;
      else if (state_q == RESP)
         resp_data_c = resp_word_q;
      if (state_q == MISS_REQ)
         mem_req_addr_c = {addr_q[ADDR_W-1:LA_W], {LA_W{1'b0}}};
   end

   always_comb begin
      pending_d = pending_q;
      if (state_q == LOOKUP)
         pending_d = accept || miss;
      else if (state_q == RESP)
         pending_d = 1'b0;
      flush_pend_d = ((state_q == MISS_REQ) || (state_q == REFILL)) && (flush_pend_q || bus.flush);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q    <= 1'b0;
         addr_q       <= '0;
         way_q        <= '0;
         evict_q      <= 1'b0;
         beat_q       <= '0;
         resp_word_q  <= '0;
         flush_pend_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         pending_q    <= pending_d;
         flush_pend_q <= flush_pend_d;
         if (accept)
            addr_q <= bus.req_addr;
         if (miss) begin
            way_q   <= fill_way;
            evict_q <= fill_evict;
         end
         if ((state_q == MISS_REQ) && bus.mem_req_ready)
            beat_q <= '0;
         else if (beat_we)
            beat_q <= beat_q + 1'b1;
         if (beat_we && (beat_q == word_f))
            resp_word_q <= bus.mem_resp_data;
         if (hit && (hit_cnt_q != '1))
            hit_cnt_q <= hit_cnt_q + 1'b1;
         if (miss && (miss_cnt_q != '1))
            miss_cnt_q <= miss_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) victim_q[s] <= '0;
      end else if (do_flush) begin
         for (int s = 0; s < SETS; s++) victim_q[s] <= '0;
      end else if (line_done && evict_q) begin
         victim_q[set_f] <= next_victim;
      end
   end

   assign bus.req_ready     = req_ready_c;
   assign bus.resp_valid    = resp_valid_c;
   assign bus.resp_hit      = resp_hit_c;
   assign bus.resp_data     = resp_data_c;
   assign bus.mem_req_valid = mem_req_valid_c;
   assign bus.mem_req_addr  = mem_req_addr_c;
   assign bus.hit_count     = hit_cnt_q;
   assign bus.miss_count    = miss_cnt_q;
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: memory model returns word = byte address for every refill beat.
module tb_icache_sa;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] last_req_addr = 32'hFFFF_FFFF;

   icache_sa_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) bus ();

   icache_sa #(
      .ADDR_W(32), .DATA_W(32), .SETS(16), .WAYS(2), .LINE_WORDS(4), .CNT_W(32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Backing memory: accept seen at negedge, beats driven 1 time unit after each following edge.
   initial begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1) begin
            last_req_addr = bus.mem_req_addr;
            for (int b = 0; b < 4; b++) begin
               @(posedge clk); #1;
               bus.mem_resp_valid = 1'b1;
               bus.mem_resp_data  = last_req_addr + 32'(4 * b);
            end
            @(posedge clk); #1;
            bus.mem_resp_valid = 1'b0;
         end
      end
   end

   task automatic do_reset();
      bus.req_valid     = 1'b0;
      bus.req_addr      = '0;
      bus.flush         = 1'b0;
      bus.mem_req_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic do_req(input logic [31:0] a, output logic [31:0] d, output logic h,
                         output int lat, output bit ok);
      int w;
      ok = 1'b0; d = '0; h = 1'b0; lat = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      w = 0;
      while (!bus.req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!bus.req_ready) begin
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            d = bus.resp_data; h = bus.resp_hit; lat = i; ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.flush = 1'b0; bus.mem_req_ready = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
      checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL reset_resp_hit: got %b expected 0", bus.resp_hit); end
      checks++; if (bus.resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", bus.resp_data); end
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b expected 0", bus.mem_req_valid); end
      checks++; if (bus.mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_req_addr: got %h expected 0", bus.mem_req_addr); end
      checks++; if (bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.hit_count, bus.miss_count); end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
      $display("reset: done");
   endtask

   task automatic test_miss();
      logic [31:0] d; logic h; int lat; bit ok;
      do_reset();
      do_req(32'h0, d, h, lat, ok);
      checks++; if (!ok || lat != 7) begin errors++; $display("FAIL miss_latency: got %0d expected 7", lat); end
      checks++; if (d !== 32'h0 || h !== 1'b0) begin errors++; $display("FAIL miss_resp: got data=%h hit=%b expected 00000000/0", d, h); end
      checks++; if (last_req_addr !== 32'h0) begin errors++; $display("FAIL miss_mem_addr: got %h expected 0", last_req_addr); end
      checks++; if (bus.miss_count !== 32'd1) begin errors++; $display("FAIL miss_count: got %0d expected 1", bus.miss_count); end
      $display("miss 0x00: lat=%0d data=%h hit=%b", lat, d, h);
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d [3];
      exp_d[0] = 32'h04; exp_d[1] = 32'h08; exp_d[2] = 32'h0C;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = exp_d[0];
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b expected 1", bus.req_ready); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (i < 2) bus.req_addr = exp_d[i+1];
         else bus.req_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b1 || bus.resp_data !== exp_d[i]) begin
            errors++;
            $display("FAIL b2b_resp%0d: got v=%b hit=%b data=%h expected 1/1/%h", i, bus.resp_valid, bus.resp_hit, bus.resp_data, exp_d[i]);
         end
         checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i + 1, bus.req_ready); end
         $display("b2b %0d: data=%h hit=%b", i, bus.resp_data, bus.resp_hit);
      end
      @(negedge clk);
      checks++; if (bus.hit_count !== 32'd3) begin errors++; $display("FAIL b2b_hit_count: got %0d expected 3", bus.hit_count); end
   endtask

   task automatic test_eviction();
      logic [31:0] addrs [6];
      logic        exp_h [6];
      logic [31:0] d; logic h; int lat; bit ok;
      addrs = '{32'h000, 32'h100, 32'h200, 32'h100, 32'h000, 32'h200};
      exp_h = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         do_req(addrs[i], d, h, lat, ok);
         checks++;
         if (!ok || h !== exp_h[i] || d !== addrs[i] || lat != (exp_h[i] ? 1 : 7)) begin
            errors++;
            $display("FAIL evict_%0d: got hit=%b data=%h lat=%0d expected hit=%b data=%h", i, h, d, lat, exp_h[i], addrs[i]);
         end
         $display("evict req %h: hit=%b lat=%0d", addrs[i], h, lat);
      end
      do_req(32'h100, d, h, lat, ok);
      checks++; if (!ok || h !== 1'b0) begin errors++; $display("FAIL evict_way1_victim: got hit=%b expected 0", h); end
   endtask

   task automatic test_mem_stall();
      int k; bit got; logic [31:0] d; logic h;
      do_reset();
      bus.mem_req_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_addr = 32'h20;
      @(posedge clk); #1 bus.req_valid = 1'b0;
      k = 0; got = 1'b0; d = '0; h = 1'b1;
      while (k < 60 && !got) begin
         @(negedge clk);
         k++;
         if (bus.resp_valid) begin
            got = 1'b1; d = bus.resp_data; h = bus.resp_hit;
         end else begin
            if (k == 1) begin
               checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL stall_lookup_ready: got %b expected 0", bus.req_ready); end
            end
            if (k >= 2 && k <= 6) begin
               checks++;
               if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h20 || bus.req_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_hold%0d: got v=%b addr=%h ready=%b expected 1/00000020/0", k, bus.mem_req_valid, bus.mem_req_addr, bus.req_ready);
               end
            end
            if (k == 6) begin
               @(posedge clk); #1 bus.mem_req_ready = 1'b1;
            end
         end
      end
      checks++; if (!got || k != 12) begin errors++; $display("FAIL stall_latency: got %0d expected 12", k); end
      checks++; if (d !== 32'h20 || h !== 1'b0 || last_req_addr !== 32'h20) begin errors++; $display("FAIL stall_resp: got data=%h hit=%b mem=%h expected 00000020/0/00000020", d, h, last_req_addr); end
      $display("stall 0x20: lat=%0d data=%h", k, d);
   endtask

   task automatic test_flush_refill();
      int k; bit got; logic [31:0] d; logic h; int lat; bit ok;
      do_reset();
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_addr = 32'h40;
      @(posedge clk); #1 bus.req_valid = 1'b0;
      k = 0;
      while (k < 40 && bus.mem_resp_valid !== 1'b1) begin @(negedge clk); k++; end
      bus.flush = 1'b1;
      @(posedge clk); #1 bus.flush = 1'b0;
      got = 1'b0; d = '0; h = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.resp_valid) begin got = 1'b1; d = bus.resp_data; h = bus.resp_hit; end
      end
      checks++; if (!got || d !== 32'h40 || h !== 1'b0) begin errors++; $display("FAIL flush_refill_resp: got v=%b data=%h hit=%b expected 1/00000040/0", got, d, h); end
      do_req(32'h40, d, h, lat, ok);
      checks++; if (!ok || h !== 1'b0 || lat != 7) begin errors++; $display("FAIL flush_refill_rereq: got hit=%b lat=%0d expected 0/7", h, lat); end
      $display("flush during refill 0x40: rereq hit=%b lat=%0d", h, lat);
      // Flush while idle: line 0x80 filled and hit, then dropped.
      do_req(32'h80, d, h, lat, ok);
      do_req(32'h80, d, h, lat, ok);
      checks++; if (!ok || h !== 1'b1) begin errors++; $display("FAIL flush_idle_prehit: got %b expected 1", h); end
      @(negedge clk);
      bus.flush = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready: got %b expected 0", bus.req_ready); end
      @(posedge clk); #1 bus.flush = 1'b0;
      do_req(32'h80, d, h, lat, ok);
      checks++; if (!ok || h !== 1'b0) begin errors++; $display("FAIL flush_idle_miss: got %b expected 0", h); end
      $display("flush idle 0x80: hit after flush=%b", h);
   endtask

   task automatic test_reset_mid();
      int k; logic [31:0] d; logic h; int lat; bit ok;
      do_reset();
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_addr = 32'h60;
      @(posedge clk); #1 bus.req_valid = 1'b0;
      k = 0;
      while (k < 40 && !(bus.mem_resp_valid === 1'b1 && bus.mem_resp_data === 32'h68)) begin @(negedge clk); k++; end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.req_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got ready=%b mreq=%b resp=%b expected 1/0/0", bus.req_ready, bus.mem_req_valid, bus.resp_valid); end
      checks++; if (bus.miss_count !== 32'd0 || bus.hit_count !== 32'd0) begin errors++; $display("FAIL rstmid_counters: got %0d/%0d expected 0/0", bus.hit_count, bus.miss_count); end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      do_req(32'h60, d, h, lat, ok);
      checks++; if (!ok || h !== 1'b0 || d !== 32'h60 || lat != 7) begin errors++; $display("FAIL rstmid_rereq: got hit=%b data=%h lat=%0d expected 0/00000060/7", h, d, lat); end
      checks++; if (bus.miss_count !== 32'd1) begin errors++; $display("FAIL rstmid_miss_count: got %0d expected 1", bus.miss_count); end
      $display("reset mid-refill 0x60: rereq hit=%b lat=%0d", h, lat);
   endtask

   initial begin
      test_reset();
      test_miss();
      test_back_to_back();
      test_eviction();
      test_mem_stall();
      test_flush_refill();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative, read-only instruction cache with a blocking miss FSM, a line refill from backing memory over a valid/ready burst, flush, and hit/miss counters. It sits between the fetch stage (request/response port) and instruction memory (refill port), and replaces the fixed direct-mapped instruction cache. Hits return one cycle after acceptance and can be issued back to back. A miss stalls the request port until the line is refilled.

## Interface
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, instruction word width; a power of two, at least 8.
- `SETS`, 16, number of sets; a power of two, at least 2.
- `WAYS`, 2, associativity; a power of two, at least 1.
- `LINE_WORDS`, 4, words per line; a power of two, at least 2.
- `CNT_W`, 32, width of the performance counters.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active low.
- `req_valid`  in  1  fetch request present.
- `req_addr`  in  ADDR_W  byte address; the low log2(DATA_W/8) bits are ignored.
- `req_ready`  out  1  cache can accept a request this cycle.
- `resp_valid`  out  1  one-cycle pulse: `resp_data` is valid.
- `resp_data`  out  DATA_W  instruction word.
- `resp_hit`  out  1  qualifies `resp_valid`: 1 = hit, 0 = filled by a refill.
- `flush`  in  1  one-cycle pulse: invalidate all lines.
- `mem_req_valid`  out  1  refill request.
- `mem_req_addr`  out  ADDR_W  line-aligned byte address.
- `mem_req_ready`  in  1  memory accepts the refill request.
- `mem_resp_valid`  in  1  refill beat present.
- `mem_resp_data`  in  DATA_W  refill beat data.
- `hit_count`  out  CNT_W  saturating count of hit responses.
- `miss_count`  out  CNT_W  saturating count of misses.

## Operation
- Address split, from LSB to MSB: byte offset (log2(DATA_W/8) bits), word index (log2 LINE_WORDS), set index (log2 SETS), tag (remaining bits).
- Per way, per set, the cache stores a valid bit, a tag and LINE_WORDS data words. Each set also has a victim pointer of log2(WAYS) bits.
- FSM states:
  - LOOKUP: default state; accepts requests.
  - MISS_REQ: drives the refill request.
  - REFILL: collects refill beats.
  - RESP: returns the missed word.
- LOOKUP:
  - A request is accepted on `req_valid && req_ready`. The cache registers the address and sets a pending flag.
  - In the next cycle, the registered address is compared against all ways of its set.
  - Hit: `resp_valid=1`, `resp_hit=1`, `resp_data` = the selected word, `hit_count` increments, and a new request may be accepted in the same cycle.
  - Miss: `req_ready=0`, `resp_valid=0`, `miss_count` increments, and the FSM moves to MISS_REQ.
- `req_ready` = (state == LOOKUP) && !(pending && miss) && !flush.
- MISS_REQ: `mem_req_valid=1` with `mem_req_addr` = the line-aligned address. It holds until `mem_req_ready`, then the FSM moves to REFILL and the beat counter clears.
- Way selection at refill:
  - If any way of the set is invalid, the lowest-index invalid way is used and the victim pointer is unchanged.
  - Otherwise the way named by the victim pointer is used, and the pointer then increments modulo WAYS.
- REFILL:
  - Each `mem_resp_valid` beat writes word[beat] of the chosen way, in order 0..LINE_WORDS-1.
  - The requested word is captured when beat == word index.
  - After the last beat, the FSM sets valid and the tag and moves to RESP.
- RESP: `resp_valid=1`, `resp_hit=0`, `resp_data` = the captured word; the FSM then returns to LOOKUP with the pending flag cleared.
- There is no response backpressure.
- `mem_resp_valid` outside REFILL is ignored.
- Flush:
  - A flush in LOOKUP clears every valid bit and every victim pointer at the next edge.
  - A pending lookup in the same cycle as a flush completes using the pre-flush tags.
  - A flush while in MISS_REQ, REFILL or RESP is latched and applied on the cycle the FSM re-enters LOOKUP. The refilled line is therefore invalidated, but its response is still delivered.
- Counters saturate at 2^CNT_W-1 and clear only on reset.

## Timing
- Reset values (asynchronous, while `rst_n=0`):
  - state = LOOKUP, pending = 0.
  - All valid bits = 0; victim pointers, beat counter and counters = 0.
  - `resp_valid=0`, `resp_hit=0`, `resp_data=0`, `mem_req_valid=0`, `mem_req_addr=0`.
  - `req_ready=1` once `rst_n=1`.
- Hit latency: 1 cycle, acceptance edge to `resp_valid`. Hit throughput is 1 per cycle.
- Miss latency: 1 (lookup) + 1 or more (MISS_REQ, until `mem_req_ready`) + LINE_WORDS or more (beats) + 1 (RESP) cycles.
  - With memory always ready and beats back to back, a miss takes 3+LINE_WORDS cycles, i.e. 7 with the defaults.
- `mem_req_valid` and `mem_req_addr` stay stable until `mem_req_ready` is sampled high.
- Reset mid-refill: the refill is abandoned and no partial line becomes valid. Later memory beats are ignored.

## Test plan
- Reset then `req_addr=0x00`; memory returns word = address: miss. `mem_req_addr=0x00`, 4 beats, then `resp_data=0x00`, `resp_hit=0` 7 cycles after acceptance; `miss_count=1`.
- Back-to-back requests 0x04, 0x08, 0x0C after that fill: 3 consecutive `resp_valid`, each with `resp_hit=1` and data 0x04/0x08/0x0C; `hit_count=3`; `req_ready` never drops.
- Requests 0x000, 0x100, 0x200 (same set 0, three tags): ways 0 and 1 fill, then the third evicts way 0 (victim pointer 0 to 1). A re-request of 0x000 misses; 0x100 still hits.
- `mem_req_ready` held low for 5 cycles in MISS_REQ: `mem_req_valid` and `mem_req_addr` are held constant and `req_ready` stays 0. The response is delayed by exactly 5 cycles.
- Flush during REFILL of 0x40: the response for 0x40 is still delivered, with `resp_hit=0`. The next request to 0x40 misses.
- `rst_n` pulsed low during beat 2 of a refill: all outputs return to their reset values immediately. The subsequent request for the same line misses and the counters are 0 before it.
